instr_encoder: RTL

//  Inverse of the decode-stage control unit. Accepts an instruction request as
//  {kind, alu_op, regs, imm} and emits the 32-bit RV32I word plus its fetch

---
 rtl/instr_encoder.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - RV32I instruction encoder with LI expansion; optional PACKED_SIMD_EN enables packed-SIMD PTYPE encodings
module instr_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          DEPTH     = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_kind,
    input  logic [5:0]  req_alu_op,
    input  logic [2:0]  req_f3,
    input  logic [4:0]  req_rd,
    input  logic [4:0]  req_rs1,
    input  logic [4:0]  req_rs2,
    input  logic [31:0] req_imm,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_word,
    output logic [31:0] instr_addr,
    output logic        err,
    output logic        wrapped
);

    localparam logic [31:0] END_ADDR   = BASE_ADDR + 32'(4 * DEPTH);
    localparam logic [6:0]  OPC_LOAD   = 7'b0000011;
    localparam logic [6:0]  OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0]  OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0]  OPC_STORE  = 7'b0100011;
    localparam logic [6:0]  OPC_OP     = 7'b0110011;
    localparam logic [6:0]  OPC_LUI    = 7'b0110111;
    localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
    localparam logic [6:0]  OPC_JALR   = 7'b1100111;
    localparam logic [6:0]  OPC_JAL    = 7'b1101111;
`ifdef PACKED_SIMD_EN
    localparam logic [6:0]  OPC_PTYPE  = 7'b1110111;
`endif

    typedef enum logic {S_IDLE, S_HOLD2} state_t;

    state_t      state_q, state_d;
    logic        valid_q, valid_d;
    logic [31:0] word_q, word_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] lo_q, lo_d;
    logic        err_q, err_d;
    logic        wrapped_q, wrapped_d;

    logic        accept, out_hs;
    logic [2:0]  alu_f3;
    logic [6:0]  alu_f7;
    logic        alu_bad, is_shift;
    logic        b_in_range, j_in_range, li_small;
    logic [19:0] lui_hi;
    logic [31:0] enc_word, enc_second;
    logic        enc_two, enc_err;

    assign accept     = req_valid && req_ready;
    assign out_hs     = valid_q && instr_ready;
    assign b_in_range = (req_imm[31:12] == {20{req_imm[12]}});
    assign j_in_range = (req_imm[31:20] == {12{req_imm[20]}});
    assign li_small   = (req_imm[31:11] == {21{req_imm[11]}});
    // ADDI sign-extends its 12-bit immediate, so the upper part absorbs bit 11
    assign lui_hi     = req_imm[31:12] + {19'd0, req_imm[11]};
    assign is_shift   = (req_alu_op == 6'd2) || (req_alu_op == 6'd6) || (req_alu_op == 6'd7);

    // ALU code to funct3/funct7, mirroring the decoder's alu_control table
    always_comb begin
        alu_f3  = 3'b000;
        alu_f7  = 7'b0000000;
        alu_bad = 1'b0;
        case (req_alu_op)
            6'd0: alu_f3 = 3'b000;
            6'd1: begin alu_f3 = 3'b000; alu_f7 = 7'b0100000; end
            6'd2: alu_f3 = 3'b001;
            6'd3: alu_f3 = 3'b010;
            6'd4: alu_f3 = 3'b011;
            6'd5: alu_f3 = 3'b100;
            6'd6: alu_f3 = 3'b101;
            6'd7: begin alu_f3 = 3'b101; alu_f7 = 7'b0100000; end
            6'd8: alu_f3 = 3'b110;
            6'd9: alu_f3 = 3'b111;
            default: alu_bad = 1'b1;
        endcase
    end

    // Request to instruction word(s); enc_err marks requests that must be dropped
    always_comb begin
        enc_word   = 32'd0;
        enc_second = 32'd0;
        enc_two    = 1'b0;
        enc_err    = 1'b0;
        case (req_kind)
            4'd0: enc_word = {req_imm[11:0], req_rs1, req_f3, req_rd, OPC_LOAD};
            4'd1: begin
                if (alu_bad || req_alu_op == 6'd1) enc_err = 1'b1;
                else if (is_shift) enc_word = {alu_f7, req_imm[4:0], req_rs1, alu_f3, req_rd, OPC_OPIMM};
                else enc_word = {req_imm[11:0], req_rs1, alu_f3, req_rd, OPC_OPIMM};
            end
            4'd2: enc_word = {req_imm[31:12], req_rd, OPC_AUIPC};
            4'd3: enc_word = {req_imm[11:5], req_rs2, req_rs1, req_f3, req_imm[4:0], OPC_STORE};
            4'd4: begin
                enc_err  = alu_bad;
                enc_word = {alu_f7, req_rs2, req_rs1, alu_f3, req_rd, OPC_OP};
            end
            4'd5: enc_word = {req_imm[31:12], req_rd, OPC_LUI};
            4'd6: begin
                enc_err  = req_imm[0] || !b_in_range || req_f3 == 3'b010 || req_f3 == 3'b011;
                enc_word = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, req_f3,
                            req_imm[4:1], req_imm[11], OPC_BRANCH};
            end
            4'd7: enc_word = {req_imm[11:0], req_rs1, 3'b000, req_rd, OPC_JALR};
            4'd8: begin
                enc_err  = req_imm[0] || !j_in_range;
                enc_word = {req_imm[20], req_imm[10:1], req_imm[11], req_imm[19:12], req_rd, OPC_JAL};
            end
`ifdef PACKED_SIMD_EN
            4'd9: begin
                case (req_alu_op)
                    6'h10: enc_word = {7'b0100000, req_rs2, req_rs1, 3'b000, req_rd, OPC_PTYPE};
                    6'h11: enc_word = {7'b0100000, req_rs2, req_rs1, 3'b001, req_rd, OPC_PTYPE};
                    6'h14: enc_word = {7'b0100100, req_rs2, req_rs1, 3'b000, req_rd, OPC_PTYPE};
                    6'h15: enc_word = {7'b0100100, req_rs2, req_rs1, 3'b001, req_rd, OPC_PTYPE};
                    default: enc_err = 1'b1;
                endcase
            end
`else
            4'd9: enc_err = 1'b1;
`endif
            4'd10: begin
                if (li_small) begin
                    enc_word = {req_imm[11:0], 5'd0, 3'b000, req_rd, OPC_OPIMM};
                end else begin
                    enc_two    = 1'b1;
                    enc_word   = {lui_hi, req_rd, OPC_LUI};
                    enc_second = {req_imm[11:0], req_rd, 3'b000, req_rd, OPC_OPIMM};
                end
            end
            default: enc_err = 1'b1;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // FSM next state: HOLD2 waits for the LUI half of a wide LI to leave
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept && !enc_err && enc_two) state_d = S_HOLD2;
            S_HOLD2: if (out_hs) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: accept only in IDLE with the output slot free or draining
    always_comb begin
        req_ready = (state_q == S_IDLE) && (!valid_q || instr_ready);
    end

    // Output slot, address counter and error pulse next-state
    always_comb begin
        valid_d   = valid_q;
        word_d    = word_q;
        addr_d    = addr_q;
        lo_d      = lo_q;
        wrapped_d = wrapped_q;
        err_d     = accept && enc_err;
        if (out_hs) begin
            if (addr_q + 32'd4 == END_ADDR) begin
                addr_d    = BASE_ADDR;
                wrapped_d = 1'b1;
            end else begin
                addr_d = addr_q + 32'd4;
            end
            valid_d = 1'b0;
        end
        if (state_q == S_HOLD2) begin
            if (out_hs) begin
                word_d  = lo_q;
                valid_d = 1'b1;
            end
        end else if (accept && !enc_err) begin
            word_d  = enc_word;
            lo_d    = enc_second;
            valid_d = 1'b1;
        end
    end

    // Output and counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q   <= 1'b0;
            word_q    <= 32'd0;
            addr_q    <= BASE_ADDR;
            lo_q      <= 32'd0;
            err_q     <= 1'b0;
            wrapped_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            word_q    <= word_d;
            addr_q    <= addr_d;
            lo_q      <= lo_d;
            err_q     <= err_d;
            wrapped_q <= wrapped_d;
        end
    end

    assign instr_valid = valid_q;
    assign instr_word  = word_q;
    assign instr_addr  = addr_q;
    assign err         = err_q;
    assign wrapped     = wrapped_q;

endmodule
